// File: rtl/sa_host_drv.sv
`default_nettype none
// ============================================================================
// Module   : sa_host_drv
// Purpose  : Host-side driver for a systolic MAC array. Streams 64 weights and
//            64 data operands into the array, clears the accumulators, kicks
//            the array off, polls its status word, then reads 64 results back
//            out through a valid/ready result stream.
// Options  : SA_HOST_TIMEOUT_EN - enables the POLL_TO poll timeout and err_o.
// Revision : 1.0 - initial release
// ============================================================================
module sa_host_drv #(
  parameter int MAC_W   = 19,
  parameter int X_W     = 8,
  parameter int POLL_TO = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_start_i,
  input  logic [X_W-1:0]   in_data_i,
  input  logic             in_v_i,
  output logic             in_rdy_o,
  output logic [7:0]       addr_o,
  output logic [31:0]      wdata_o,
  output logic             wr_vo,
  input  logic [MAC_W-1:0] rdata_i,
  output logic [MAC_W-1:0] res_o,
  output logic             res_v_o,
  input  logic             res_rdy_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [5:0] c_LAST_K   = 6'd63;  // last operand / result index
  localparam logic [5:0] c_LAST_CLR = 6'd7;   // last accumulator clear index

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_W = 4'd1,
    S_LOAD_X = 4'd2,
    S_CLR    = 4'd3,
    S_START  = 4'd4,
    S_GAP    = 4'd5,
    S_POLL   = 4'd6,
    S_READ   = 4'd7,
    S_FIN    = 4'd8
  } state_t;

  state_t           r_state;
  logic [5:0]       r_k;       // per-phase index, never wraps past its terminal value
  logic             r_phase;   // second cycle of a 2-cycle read slot
  logic [MAC_W-1:0] r_res;
  logic             r_res_v;

  logic [7:0]       w_addr;
  logic [31:0]      w_wdata;
  logic             w_wr;
  logic             w_rdy;

`ifdef SA_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(POLL_TO + 1);
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;
`else
  // The timeout parameter has no hardware in this build.
  logic w_unused_poll_to;
  assign w_unused_poll_to = (POLL_TO != 0);
`endif

  // Array-side bus decode: address, data and strobe follow state and index so
  // a load handshake writes in the very cycle it happens.
  always_comb begin
    w_addr  = 8'd0;
    w_wdata = 32'd0;
    w_wr    = 1'b0;
    w_rdy   = 1'b0;
    case (r_state)
      S_LOAD_W: begin
        w_rdy   = 1'b1;
        w_addr  = {2'b00, r_k};
        w_wdata = 32'(in_data_i);
        w_wr    = in_v_i;
      end
      S_LOAD_X: begin
        w_rdy   = 1'b1;
        w_addr  = {2'b01, r_k};
        w_wdata = 32'(in_data_i);
        w_wr    = in_v_i;
      end
      S_CLR: begin
        w_addr = {5'b10000, r_k[2:0]};
        w_wr   = 1'b1;
      end
      S_START: begin
        w_addr = 8'd192;
        w_wr   = 1'b1;
      end
      S_READ:  w_addr = {2'b10, r_k};
      default: ;
    endcase
  end

  // Job sequencer: load, clear, start, poll for completion, read back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_k      <= 6'd0;
      r_phase  <= 1'b0;
      r_res    <= '0;
      r_res_v  <= 1'b0;
`ifdef SA_HOST_TIMEOUT_EN
      r_err    <= 1'b0;
      r_to_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_start_i) begin
            r_state <= S_LOAD_W;
            r_k     <= 6'd0;
`ifdef SA_HOST_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_LOAD_W: begin
          if (in_v_i) begin
            if (r_k == c_LAST_K) begin
              r_k     <= 6'd0;
              r_state <= S_LOAD_X;
            end else begin
              r_k <= r_k + 6'd1;
            end
          end
        end
        S_LOAD_X: begin
          if (in_v_i) begin
            if (r_k == c_LAST_K) begin
              r_k     <= 6'd0;
              r_state <= S_CLR;
            end else begin
              r_k <= r_k + 6'd1;
            end
          end
        end
        S_CLR: begin
          if (r_k == c_LAST_CLR) begin
            r_k     <= 6'd0;
            r_state <= S_START;
          end else begin
            r_k <= r_k + 6'd1;
          end
        end
        S_START: r_state <= S_GAP;
        S_GAP: begin
          r_phase <= 1'b0;
`ifdef SA_HOST_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state <= S_POLL;
        end
        S_POLL: begin
          r_phase <= ~r_phase;
          if (r_phase && rdata_i[0]) begin
            r_phase <= 1'b0;
            r_k     <= 6'd0;
            r_state <= S_READ;
          end
`ifdef SA_HOST_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(POLL_TO - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_READ: begin
          if (!r_res_v) begin
            if (r_phase) begin
              r_res   <= rdata_i;
              r_res_v <= 1'b1;
            end else begin
              r_phase <= 1'b1;
            end
          end else if (res_rdy_i) begin
            r_res_v <= 1'b0;
            r_phase <= 1'b0;
            if (r_k == c_LAST_K) begin
              r_k     <= 6'd0;
              r_state <= S_FIN;
            end else begin
              r_k <= r_k + 6'd1;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr_o   = w_addr;
  assign wdata_o  = w_wdata;
  assign wr_vo    = w_wr;
  assign in_rdy_o = w_rdy;
  assign res_o    = r_res;
  assign res_v_o  = r_res_v;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_FIN);
`ifdef SA_HOST_TIMEOUT_EN
  assign err_o    = r_err;
`else
  assign err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sa_host_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_host_drv
// Purpose  : Directed self-checking bench for sa_host_drv with a simple array
//            model (status word at address 0, results at 128..191).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_host_drv;

  localparam int MAC_W = 19;
  localparam int X_W   = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_start_i = 1'b0;
  logic [X_W-1:0]   in_data_i = '0;
  logic             in_v_i = 1'b0;
  logic             in_rdy_o;
  logic [7:0]       addr_o;
  logic [31:0]      wdata_o;
  logic             wr_vo;
  logic [MAC_W-1:0] rdata_i;
  logic [MAC_W-1:0] res_o;
  logic             res_v_o;
  logic             res_rdy_i = 1'b1;
  logic             busy_o, done_o, err_o;

  sa_host_drv #(.MAC_W(MAC_W), .X_W(X_W), .POLL_TO(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_start_i(cmd_start_i),
    .in_data_i(in_data_i), .in_v_i(in_v_i), .in_rdy_o(in_rdy_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_vo(wr_vo), .rdata_i(rdata_i),
    .res_o(res_o), .res_v_o(res_v_o), .res_rdy_i(res_rdy_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  // Bench state shared by driver, monitor and array model
  int         seed = 0;
  int         status_delay = 24;
  bit         start_seen = 0;
  int         st_cnt = 0;
  logic       status = 1'b0;
  int         done_cnt = 0;
  int         ncyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  logic [7:0]       wa[$];
  logic [31:0]      wd[$];
  logic [MAC_W-1:0] res_q[$];
  int  n_lstall, hold_bad, n_stall, rstall_bad;
  bit  timed_out;

  function automatic logic [7:0] op_val(input int i, input int s);
    return 8'((i * 37 + 11 + s) & 255);
  endfunction

  function automatic logic [MAC_W-1:0] res_val(input int k, input int s);
    return MAC_W'(k * 4099 + 74565 + s * 13);
  endfunction

  // Array model: status at address 0, one result word per address 128..191
  always_comb begin
    rdata_i = '0;
    if (addr_o == 8'd0) rdata_i[0] = status;
    else if (addr_o >= 8'd128 && addr_o < 8'd192) rdata_i = res_val(int'(addr_o) - 128, seed);
  end

  // Monitor: mid-cycle sampling of writes, results and done pulses
  always @(negedge clk_i) begin
    ncyc++;
    if (!rst_i) begin
      if (wr_vo) begin
        wa.push_back(addr_o);
        wd.push_back(wdata_o);
        if (addr_o == 8'd192) begin
          start_seen = 1;
          start_cyc  = ncyc;
        end
      end
      if (start_seen) st_cnt++;
      status = start_seen && (st_cnt >= status_delay);
      if (res_v_o && res_rdy_i) res_q.push_back(res_o);
      if (done_o) begin
        done_cnt++;
        done_cyc = ncyc;
      end
    end
  end

  function automatic int count_write_errs(input int s);
    int e = 0;
    logic [7:0]  ea;
    logic [31:0] ed;
    if (wa.size() != 137) return 999;
    for (int i = 0; i < 137; i++) begin
      ea = (i < 136) ? 8'(i) : 8'd192;
      ed = (i < 128) ? {24'd0, op_val(i, s)} : 32'd0;
      if (wa[i] !== ea || wd[i] !== ed) e++;
    end
    return e;
  endfunction

  function automatic int count_res_errs(input int s);
    int e = 0;
    if (res_q.size() != 64) return 999;
    for (int k = 0; k < 64; k++) if (res_q[k] !== res_val(k, s)) e++;
    return e;
  endfunction

  // Runs one job; abort_at >= 0 returns while the given operand is on the bus
  task automatic drive_job(input int s, input bit tog, input int stall_k,
                           input bit poke, input int abort_at);
    int idx = 0;
    int cyc = 0;
    seed = s;
    wa.delete(); wd.delete(); res_q.delete();
    start_seen = 0; st_cnt = 0; status = 1'b0; done_cnt = 0;
    n_lstall = 0; hold_bad = 0; n_stall = 0; rstall_bad = 0;
    @(posedge clk_i); #1;
    cmd_start_i = 1'b1; in_v_i = 1'b0;
    @(posedge clk_i); #1;
    cmd_start_i = 1'b0;
    while (done_cnt == 0 && cyc < 3000) begin
      in_v_i      = (idx < 128) && (!tog || (cyc % 2 == 1));
      in_data_i   = op_val(idx, s);
      res_rdy_i   = !(stall_k >= 0 && res_q.size() == stall_k && n_stall < 5);
      cmd_start_i = poke && start_seen && (st_cnt == 5);
      if (abort_at >= 0 && idx == abort_at) break;
      @(negedge clk_i);
      if (in_rdy_o && in_v_i) idx++;
      else if (in_rdy_o) begin
        n_lstall++;
        if (wr_vo !== 1'b0 || addr_o !== 8'(idx)) hold_bad++;
      end
      if (res_v_o && !res_rdy_i) begin
        n_stall++;
        if (addr_o !== 8'(128 + stall_k) || res_o !== res_val(stall_k, s)) rstall_bad++;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    timed_out = (abort_at < 0) && (done_cnt == 0);
    if (abort_at < 0) begin
      cmd_start_i = 1'b0; in_v_i = 1'b0; res_rdy_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_o); else n_pass++;
    n_chk++; if (wr_vo !== 1'b0) $display("FAIL rst_wr: got %0b want 0", wr_vo); else n_pass++;
    n_chk++; if (in_rdy_o !== 1'b0) $display("FAIL rst_rdy: got %0b want 0", in_rdy_o); else n_pass++;
    n_chk++; if (addr_o !== 8'd0) $display("FAIL rst_addr: got %0d want 0", addr_o); else n_pass++;
    n_chk++; if (wdata_o !== 32'd0) $display("FAIL rst_wdata: got %0h want 0", wdata_o); else n_pass++;
    n_chk++; if (res_v_o !== 1'b0) $display("FAIL rst_resv: got %0b want 0", res_v_o); else n_pass++;
    n_chk++; if (res_o !== '0) $display("FAIL rst_res: got %0h want 0", res_o); else n_pass++;
    n_chk++; if (done_o !== 1'b0) $display("FAIL rst_done: got %0b want 0", done_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL rst_err: got %0b want 0", err_o); else n_pass++;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_full_job();
    int e;
    drive_job(1, 1'b0, -1, 1'b0, -1);
    n_chk++; if (timed_out) $display("FAIL full_done: got no done want done"); else n_pass++;
    e = count_write_errs(1);
    n_chk++; if (e != 0) $display("FAIL full_writes: got %0d bad (n=%0d) want 0", e, wa.size()); else n_pass++;
    e = count_res_errs(1);
    n_chk++; if (e != 0) $display("FAIL full_results: got %0d bad (n=%0d) want 0", e, res_q.size()); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL full_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL full_idle: got busy %0b want 0", busy_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL full_err: got %0b want 0", err_o); else n_pass++;
  endtask

  task automatic test_valid_toggle();
    int e;
    drive_job(2, 1'b1, -1, 1'b0, -1);
    n_chk++; if (n_lstall < 64) $display("FAIL tog_stalls: got %0d want >=64", n_lstall); else n_pass++;
    n_chk++; if (hold_bad != 0) $display("FAIL tog_hold: got %0d bad want 0", hold_bad); else n_pass++;
    e = count_write_errs(2);
    n_chk++; if (e != 0) $display("FAIL tog_writes: got %0d bad (n=%0d) want 0", e, wa.size()); else n_pass++;
    e = count_res_errs(2);
    n_chk++; if (e != 0) $display("FAIL tog_results: got %0d bad want 0", e); else n_pass++;
  endtask

  task automatic test_res_stall();
    int e;
    drive_job(3, 1'b0, 7, 1'b0, -1);
    n_chk++; if (n_stall != 5) $display("FAIL stall_cycles: got %0d want 5", n_stall); else n_pass++;
    n_chk++; if (rstall_bad != 0) $display("FAIL stall_hold: got %0d bad want 0", rstall_bad); else n_pass++;
    e = count_res_errs(3);
    n_chk++; if (e != 0) $display("FAIL stall_results: got %0d bad (n=%0d) want 0", e, res_q.size()); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_cmd_in_poll();
    int e;
    drive_job(4, 1'b0, -1, 1'b1, -1);
    e = count_write_errs(4);
    n_chk++; if (e != 0) $display("FAIL poke_writes: got %0d bad (n=%0d) want 0", e, wa.size()); else n_pass++;
    e = count_res_errs(4);
    n_chk++; if (e != 0) $display("FAIL poke_results: got %0d bad want 0", e); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL poke_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL poke_idle: got busy %0b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int e;
    drive_job(5, 1'b0, -1, 1'b0, 74);
    #1;
    n_chk++; if (addr_o !== 8'd74) $display("FAIL mid_addr: got %0d want 74", addr_o); else n_pass++;
    rst_i = 1'b1;
    #1;
    n_chk++; if (wr_vo !== 1'b0) $display("FAIL mid_rst_wr: got %0b want 0", wr_vo); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL mid_rst_busy: got %0b want 0", busy_o); else n_pass++;
    n_chk++; if (addr_o !== 8'd0) $display("FAIL mid_rst_addr: got %0d want 0", addr_o); else n_pass++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wa.delete(); wd.delete();
    in_v_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    n_chk++; if (busy_o !== 1'b0 || wa.size() != 0)
      $display("FAIL mid_no_resume: got busy %0b writes %0d want 0 0", busy_o, wa.size()); else n_pass++;
    drive_job(6, 1'b0, -1, 1'b0, -1);
    n_chk++; if (wa.size() == 0 || wa[0] !== 8'd0)
      $display("FAIL mid_restart_addr: got %0d want 0", (wa.size() == 0) ? -1 : int'(wa[0])); else n_pass++;
    e = count_write_errs(6);
    n_chk++; if (e != 0) $display("FAIL mid_restart_writes: got %0d bad want 0", e); else n_pass++;
  endtask

`ifdef SA_HOST_TIMEOUT_EN
  task automatic test_timeout();
    status_delay = 1 << 30;
    drive_job(7, 1'b0, -1, 1'b0, -1);
    n_chk++; if (timed_out) $display("FAIL to_done: got no done want done"); else n_pass++;
    n_chk++; if (err_o !== 1'b1) $display("FAIL to_err: got %0b want 1", err_o); else n_pass++;
    n_chk++; if (res_q.size() != 0) $display("FAIL to_no_read: got %0d results want 0", res_q.size()); else n_pass++;
    n_chk++; if (done_cyc - start_cyc != 257)
      $display("FAIL to_poll_len: got %0d want 257", done_cyc - start_cyc); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL to_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    status_delay = 24;
  endtask
`else
  task automatic test_poll_wait();
    int e;
    status_delay = 400;
    drive_job(8, 1'b0, -1, 1'b0, -1);
    n_chk++; if (timed_out) $display("FAIL wait_done: got no done want done"); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL wait_err: got %0b want 0", err_o); else n_pass++;
    e = count_res_errs(8);
    n_chk++; if (e != 0) $display("FAIL wait_results: got %0d bad (n=%0d) want 0", e, res_q.size()); else n_pass++;
    status_delay = 24;
  endtask
`endif

  initial begin
    test_reset();
    test_full_job();
    test_valid_toggle();
    test_res_stall();
    test_cmd_in_poll();
    test_reset_mid_load();
`ifdef SA_HOST_TIMEOUT_EN
    test_timeout();
`else
    test_poll_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sa_host_drv.md
SA_HOST_DRV -- requirements
Module: sa_host_drv

Interface
REQ-001 Parameter MAC_W, default 19, SHALL set the result width returned by the array.
REQ-002 Parameter X_W, default 8, SHALL set the weight/data operand width.
REQ-003 Parameter POLL_TO, default 255, SHALL set the poll timeout in cycles; it SHALL be used only when SA_HOST_TIMEOUT_EN is defined.
REQ-004 clk_i  input  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-005 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 cmd_start_i  input  1  SHALL be a one-cycle job request.
REQ-007 in_data_i  input  X_W  SHALL carry the operand stream: 64 weights, then 64 data values.
REQ-008 in_v_i / in_rdy_o  input / output  1 / 1  SHALL form the valid/ready pair for the operand stream.
REQ-009 addr_o  output  8  SHALL be the array-side address.
REQ-010 wdata_o  output  32  SHALL be the array-side write data, zero-extended.
REQ-011 wr_vo  output  1  SHALL be the array-side write strobe.
REQ-012 rdata_i  input  MAC_W  SHALL be the array-side read data, carrying status or result.
REQ-013 res_o / res_v_o / res_rdy_i  output / output / input  MAC_W / 1 / 1  SHALL form the result stream.
REQ-014 busy_o, done_o, err_o  output  1 each  SHALL flag job active, job complete (one-cycle pulse) and poll timeout, respectively.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD_W, LOAD_X, CLR, START, GAP, POLL, READ and FIN.
REQ-016 IDLE SHALL go to LOAD_W on cmd_start_i=1; cmd_start_i SHALL be ignored in every other state.
REQ-017 In LOAD_W, each in_v_i&in_rdy_o handshake SHALL issue one write in the same cycle: addr_o=k (k=0..63), wdata_o=in_data_i, wr_vo=1. After k=63 the state SHALL go to LOAD_X.
REQ-018 LOAD_X SHALL behave the same, with addr_o=64+k; after k=63 it SHALL go to CLR.
REQ-019 in_rdy_o SHALL be 1 only in LOAD_W and LOAD_X; in_v_i=0 SHALL stall with wr_vo=0, and the address SHALL be held.
REQ-020 CLR SHALL issue 8 consecutive writes to addr_o=128..135 with wdata_o=0, then go to START.
REQ-021 START SHALL issue one write to addr_o=192 with wdata_o=0, then go to GAP.
REQ-022 GAP SHALL last 1 cycle with wr_vo=0 and addr_o=0, and SHALL then go to POLL.
REQ-023 POLL SHALL hold addr_o=0 with wr_vo=0 and sample rdata_i[0] on every second cycle of each 2-cycle read slot.
REQ-024 POLL SHALL go to READ when the sampled rdata_i[0] is 1.
REQ-025 READ SHALL read k=0..63 at addr_o=128+k, holding each address for 2 cycles and capturing rdata_i in the second cycle into res_o with res_v_o=1.
REQ-026 res_o SHALL hold while res_v_o=1 and res_rdy_i=0; the next address SHALL be presented only after res_v_o&res_rdy_i.
REQ-027 After the k=63 handshake, READ SHALL go to FIN; FIN SHALL pulse done_o=1 for 1 cycle and return to IDLE.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 wr_vo SHALL be 0 in GAP, POLL, READ, FIN and IDLE.
REQ-030 Address counters SHALL be 6 bits and SHALL NOT wrap past the terminal value of their phase.

Reset
REQ-031 Asserting rst_i at any time, including mid-job, SHALL immediately force IDLE, with addr_o, wdata_o, wr_vo, in_rdy_o, res_o, res_v_o, busy_o, done_o and err_o all 0 and all counters 0.
REQ-032 After rst_i deasserts, the block SHALL wait for a new cmd_start_i, and no partial job SHALL resume.

Configuration
REQ-033 With SA_HOST_TIMEOUT_EN defined, a counter SHALL run in POLL; if POLL_TO cycles elapse without status=1, err_o SHALL go to 1 (sticky until reset or the next cmd_start_i) and the state SHALL go to FIN.
REQ-034 With SA_HOST_TIMEOUT_EN undefined, POLL SHALL wait indefinitely and err_o SHALL be tied to 0.

Verification
REQ-035 Reset mid-LOAD_X (k=10): assert rst_i -> wr_vo=0 and busy_o=0 in the same cycle; the next job starts at addr_o=0.
REQ-036 Full job with in_v_i always 1, res_rdy_i always 1, and status=1 returned 24 cycles after START -> 128 load writes, 8 clear writes, write at 192, 64 results in address order, done_o pulses once.
REQ-037 in_v_i toggling 1/0 in LOAD_W -> exactly 64 writes to addr_o=0..63, none duplicated, with addr_o held during stalls.
REQ-038 res_rdy_i=0 for 5 cycles at k=7 -> res_o stable, addr_o held at 135, no results lost.
REQ-039 cmd_start_i pulsed during POLL -> ignored; job completes normally.
REQ-040 SA_HOST_TIMEOUT_EN defined, status held at 0 -> err_o=1 after 255 POLL cycles, done_o pulses, no READ performed.
